// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch controller: FSM states, speed codes and
// the speed-code to BCD display table.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam logic [1:0] SPD_2X   = 2'd0;
    localparam logic [1:0] SPD_1X   = 2'd1;
    localparam logic [1:0] SPD_HALF = 2'd2;
    localparam logic [1:0] SPD_MIN  = SPD_2X;
    localparam logic [1:0] SPD_MAX  = SPD_HALF;

    // Returns {tens, units} of the speed multiplier shown on the display.
    function automatic logic [7:0] spd_to_bcd(input logic [1:0] code);
        logic [7:0] bcd;
        bcd = 8'h10;
        case (code)
            SPD_2X:   bcd = 8'h20;
            SPD_1X:   bcd = 8'h10;
            SPD_HALF: bcd = 8'h05;
            default:  bcd = 8'h10;
        endcase
        return bcd;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Period divider: counts clk cycles while running, period SEC_CYCLES << shift.
// tick is combinational so the controller's registered count_en lands exactly P cycles after RUN entry.
module tick_divider #(
    parameter int SEC_CYCLES = 12500000,
    parameter int DIV_W      = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       zero,
    input  logic [1:0] shift,
    output logic       tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;
    logic             at_last;

    assign last    = (DIV_W'(SEC_CYCLES) << shift) - DIV_W'(1);
    assign at_last = (cnt == last);
    // A zeroing request (speed change, clear, fresh start) also swallows a coincident tick.
    assign tick    = run && !zero && at_last;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || zero) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= at_last ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns debounced button pulses into one-cycle count enables,
// direction, clear and speed selection for the mm:ss datapath.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int SEC_CYCLES = 12500000,
    parameter int DIV_W      = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_p,
    input  logic       dir_p,
    input  logic       fast_p,
    input  logic       slow_p,
    input  logic       clear_p,
    input  logic       at_zero,
    output logic       count_en,
    output logic       count_dn,
    output logic       clr_digits,
    output logic [1:0] spd_code,
    output logic [3:0] spd_bcd1,
    output logic [3:0] spd_bcd0,
    output logic [1:0] state_o,
    output logic       alarm
);

    state_t     state;
    logic [1:0] spd_next;
    logic       spd_chg;
    logic       div_zero;
    logic       tick;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        spd_next = spd_code;
        if (fast_p && !slow_p && spd_code != SPD_MIN) begin
            spd_next = spd_code - 2'd1;
        end else if (slow_p && !fast_p && spd_code != SPD_MAX) begin
            spd_next = spd_code + 2'd1;
        end
    end

    assign spd_chg  = (spd_next != spd_code);
    assign div_zero = spd_chg || clear_p || (start_p && state == ST_IDLE);

    tick_divider #(
        .SEC_CYCLES(SEC_CYCLES),
        .DIV_W     (DIV_W)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .run  (state == ST_RUN),
        .zero (div_zero),
        .shift(spd_code),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            count_dn   <= 1'b0;
            count_en   <= 1'b0;
            clr_digits <= 1'b0;
            alarm      <= 1'b0;
            spd_code   <= SPD_1X;
            {spd_bcd1, spd_bcd0} <= spd_to_bcd(SPD_1X);
        end else begin
            count_en   <= 1'b0;
            clr_digits <= 1'b0;
            spd_code   <= spd_next;
            {spd_bcd1, spd_bcd0} <= spd_to_bcd(spd_next);

            if (clear_p) begin
                state      <= ST_IDLE;
                alarm      <= 1'b0;
                clr_digits <= 1'b1;
            end else if (start_p) begin
                case (state)
                    ST_IDLE:  state <= ST_RUN;
                    ST_RUN:   state <= ST_PAUSE;
                    ST_PAUSE: state <= ST_RUN;
                    ST_ALARM: begin
                        state <= ST_IDLE;
                        alarm <= 1'b0;
                    end
                    default:  state <= ST_IDLE;
                endcase
            end else begin
                if (dir_p && (state == ST_IDLE || state == ST_PAUSE)) begin
                    count_dn <= ~count_dn;
                end
                // Counting down into 00:00 stops in ALARM instead of wrapping to 59:59.
                if (tick) begin
                    if (count_dn && at_zero) begin
                        state <= ST_ALARM;
                        alarm <= 1'b1;
                    end else begin
                        count_en <= 1'b1;
                    end
                end
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random pulses,
// every cycle compared against a behavioural model of the stopwatch rules.
module tb_stopwatch_ctrl;

    localparam int SEC = 4;

    logic       clk = 1'b0;
    logic       rst, start_p, dir_p, fast_p, slow_p, clear_p, at_zero;
    logic       count_en, count_dn, clr_digits, alarm;
    logic [1:0] spd_code, state_o;
    logic [3:0] spd_bcd1, spd_bcd0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: state 0..3, direction, speed, RUN cycles since divider zero.
    int m_state, m_dn, m_spd, m_elapsed, m_en, m_clr;

    stopwatch_ctrl #(.SEC_CYCLES(SEC), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .start_p(start_p), .dir_p(dir_p), .fast_p(fast_p),
        .slow_p(slow_p), .clear_p(clear_p), .at_zero(at_zero), .count_en(count_en),
        .count_dn(count_dn), .clr_digits(clr_digits), .spd_code(spd_code),
        .spd_bcd1(spd_bcd1), .spd_bcd0(spd_bcd0), .state_o(state_o), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int bcd_of(input int spd);
        // Display reads the multiplier: 2.0x, 1.0x, 0.5x
        if (spd == 0) return 8'h20;
        if (spd == 1) return 8'h10;
        return 8'h05;
    endfunction

    task automatic model(input logic r, s, d, f, sl, c, z);
        int period, spd_new, tick;
        m_en  = 0;
        m_clr = 0;
        if (r) begin
            m_state = 0; m_dn = 0; m_spd = 1; m_elapsed = 0;
            return;
        end
        period  = SEC * (1 << m_spd);
        spd_new = m_spd;
        if (f && !sl) spd_new = (m_spd > 0) ? m_spd - 1 : 0;
        if (sl && !f) spd_new = (m_spd < 2) ? m_spd + 1 : 2;
        tick = (m_state == 1) && (m_elapsed + 1 == period) && (spd_new == m_spd) && !c;
        if (spd_new != m_spd || c || (s && m_state == 0)) m_elapsed = 0;
        else if (m_state == 1) m_elapsed = (m_elapsed + 1) % period;
        m_spd = spd_new;
        if (c) begin
            m_state = 0; m_clr = 1;
        end else if (s) begin
            m_state = (m_state == 0) ? 1 : (m_state == 1) ? 2 : (m_state == 2) ? 1 : 0;
        end else begin
            if (d && (m_state == 0 || m_state == 2)) m_dn = 1 - m_dn;
            if (tick) begin
                if (m_dn == 1 && z) m_state = 3;
                else m_en = 1;
            end
        end
    endtask

    task automatic step(input logic r, s, d, f, sl, c, z);
        @(negedge clk);
        rst = r; start_p = s; dir_p = d; fast_p = f; slow_p = sl; clear_p = c; at_zero = z;
        model(r, s, d, f, sl, c, z);
        @(posedge clk);
        #1;
        check("state", state_o, m_state);
        check("count_en", count_en, m_en);
        check("clr_digits", clr_digits, m_clr);
        check("count_dn", count_dn, m_dn);
        check("spd_code", spd_code, m_spd);
        check("spd_bcd", {spd_bcd1, spd_bcd0}, bcd_of(m_spd));
        check("alarm", alarm, (m_state == 3) ? 1 : 0);
    endtask

    task automatic idle(input int n, input logic z);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, z);
    endtask

    initial begin
        {rst, start_p, dir_p, fast_p, slow_p, clear_p, at_zero} = '0;
        m_state = 0; m_dn = 0; m_spd = 1; m_elapsed = 0;

        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_state", state_o, 0);
        check("rst_spd", spd_code, 1);
        check("rst_bcd", {spd_bcd1, spd_bcd0}, 8'h10);

        // Start, then measure speed-1 period of 8.
        step(0, 1, 0, 0, 0, 0, 0);
        check("run_entry", state_o, 1);
        idle(7, 0);
        check("no_early_tick", count_en, 0);
        idle(1, 0);
        check("first_tick_8", count_en, 1);
        idle(8, 0);

        // Speed saturation both ways, then fast+slow together.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0);
        check("spd_sat_min", spd_code, 0);
        check("bcd_2x", {spd_bcd1, spd_bcd0}, 8'h20);
        idle(12, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0);
        check("spd_sat_max", spd_code, 2);
        check("bcd_half", {spd_bcd1, spd_bcd0}, 8'h05);
        idle(40, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        check("fast_slow_same", spd_code, 2);
        idle(10, 0);
        step(0, 0, 0, 1, 0, 0, 0);

        // Pause with divider at 5, hold, resume: tick 3 cycles later.
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(4, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("paused", state_o, 2);
        idle(20, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(2, 0);
        check("resume_no_tick", count_en, 0);
        idle(1, 0);
        check("resume_tick_3", count_en, 1);

        // dir_p ignored in RUN, honoured in PAUSE; countdown at zero alarms.
        step(0, 0, 1, 0, 0, 0, 0);
        check("dir_in_run", count_dn, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        check("dir_in_pause", count_dn, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(10, 1);
        check("alarm_state", state_o, 3);
        check("alarm_out", alarm, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        check("ack_idle", state_o, 0);
        check("ack_alarm_low", alarm, 0);

        // Clear on the tick cycle.
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(7, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("clr_drops_tick", count_en, 0);
        check("clr_pulse", clr_digits, 1);
        check("clr_idle", state_o, 0);
        check("clr_keeps_spd", spd_code, 1);
        idle(1, 0);
        check("clr_one_cycle", clr_digits, 0);

        // Reset mid-RUN.
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(5, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_mid_state", state_o, 0);
        check("rst_mid_dn", count_dn, 0);
        check("rst_mid_spd", spd_code, 1);

        // Random pulses.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
